// File: rtl/sdram_port_arbiter_if.sv
// Avalon-MM bundle between the two requesting masters and the shared SDRAM controller slave.
// Port p of each packed r_* vector occupies slice [p*W +: W].
interface sdram_port_arbiter_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16
);
  localparam int BE_W = DATA_W / 8;

  // Upstream side: two masters.
  logic [2*ADDR_W-1:0] r_address;
  logic [1:0]          r_read;
  logic [1:0]          r_write;
  logic [2*DATA_W-1:0] r_writedata;
  logic [2*BE_W-1:0]   r_byteenable;
  logic [1:0]          r_waitrequest;
  logic [DATA_W-1:0]   r_readdata;
  logic [1:0]          r_readdatavalid;

  // Downstream side: SDRAM controller.
  logic [ADDR_W-1:0]   av_address;
  logic [DATA_W-1:0]   av_writedata;
  logic [BE_W-1:0]     av_byteenable;
  logic                av_read;
  logic                av_write;
  logic                av_waitrequest;
  logic [DATA_W-1:0]   av_readdata;
  logic                av_readdatavalid;

  modport slave (
    input  r_address, r_read, r_write, r_writedata, r_byteenable,
           av_waitrequest, av_readdata, av_readdatavalid,
    output r_waitrequest, r_readdata, r_readdatavalid,
           av_address, av_writedata, av_byteenable, av_read, av_write
  );

  modport master (
    output r_address, r_read, r_write, r_writedata, r_byteenable,
           av_waitrequest, av_readdata, av_readdatavalid,
    input  r_waitrequest, r_readdata, r_readdatavalid,
           av_address, av_writedata, av_byteenable, av_read, av_write
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Two-port Avalon-MM arbiter in front of one SDRAM controller, with a tag FIFO steering read returns.
// Define SDRAM_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins); the default is round-robin.
module sdram_port_arbiter #(
  parameter int ADDR_W     = 24,
  parameter int DATA_W     = 16,
  parameter int PEND_DEPTH = 4
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset,
  sdram_port_arbiter_if.slave  bus,
  output logic                 arb_err
);
  localparam int PTR_W = $clog2(PEND_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;

  state_t           state, state_nx;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             tag_mem [PEND_DEPTH];

  logic [1:0] elig, cand, win;
  logic       granted, gnt, sel_read, sel_write;
  logic       accept, push, pop, fifo_full, fifo_empty, err_ev;

  assign granted    = (state != IDLE);
  assign gnt        = (state == BUSY1);
  assign sel_read   = granted & bus.r_read[gnt];
  assign sel_write  = granted & bus.r_write[gnt];
  assign accept     = granted & ~bus.av_waitrequest;

  assign fifo_full  = (count == CNT_W'(PEND_DEPTH));
  assign fifo_empty = (count == '0);
  // A read only waits on a full FIFO; the registered count means a same-cycle pop does not help.
  assign elig       = (bus.r_read | bus.r_write) & ~(bus.r_read & {2{fifo_full}});

  assign push   = accept & sel_read;
  assign pop    = bus.av_readdatavalid & ~fifo_empty;
  assign err_ev = (bus.av_readdatavalid & fifo_empty) | (sel_read & sel_write);

`ifdef SDRAM_ARB_FIXED_PRIO_EN
  // Without a fairness pointer the granted port may be re-granted at once, which is how port 0 holds the bus.
  always_comb begin
    cand = elig;
    win  = cand[0] ? 2'b01 : cand;
  end
`else
  logic last;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    cand = elig;
    if (accept) cand[gnt] = 1'b0;
    if (&cand) win = last ? 2'b01 : 2'b10;
    else       win = cand;
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset)  last <= 1'b1;
    else if (accept)  last <= gnt;
  end
`endif

  always_comb begin
    state_nx = state;
    if (state == IDLE || accept) begin
      if (win[0])      state_nx = BUSY0;
      else if (win[1]) state_nx = BUSY1;
      else             state_nx = IDLE;
    end
  end

  always_comb begin
    bus.av_address    = '0;
    bus.av_writedata  = '0;
    bus.av_byteenable = '0;
    bus.av_read       = 1'b0;
    bus.av_write      = 1'b0;
    bus.r_waitrequest = 2'b11;
    if (granted) begin
      bus.av_address    = gnt ? bus.r_address[ADDR_W +: ADDR_W] : bus.r_address[0 +: ADDR_W];
      bus.av_writedata  = gnt ? bus.r_writedata[DATA_W +: DATA_W] : bus.r_writedata[0 +: DATA_W];
      bus.av_byteenable = gnt ? bus.r_byteenable[DATA_W/8 +: DATA_W/8]
                              : bus.r_byteenable[0 +: DATA_W/8];
      // A read+write collision performs the read only.
      bus.av_read       = sel_read;
      bus.av_write      = sel_write & ~sel_read;
      bus.r_waitrequest[gnt] = bus.av_waitrequest;
    end
  end

  always_comb begin
    bus.r_readdatavalid = 2'b00;
    if (pop) bus.r_readdatavalid[tag_mem[rd_ptr]] = 1'b1;
  end

  assign bus.r_readdata = bus.av_readdata;

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      arb_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (err_ev) arb_err <= 1'b1;
    end
  end

  // NOTE: tag storage is not reset; the pointers and count define which entries are live.
  always_ff @(posedge clk_clk) begin
    if (push) tag_mem[wr_ptr] <= gnt;
  end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter: expected accepts and read returns are queued at issue
// time and popped when the SDRAM side accepts a command or a return strobe appears.
module tb_sdram_port_arbiter;
  localparam int ADDR_W = 24;
  localparam int DATA_W = 16;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [23:0] addr;
    logic [15:0] data;
  } cmd_t;

  typedef struct {
    int          due;
    logic [15:0] data;
  } ret_t;

  logic clk = 1'b0;
  logic rst;
  logic arb_err;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   lat;
  bit   rdv_hold;
  bit   inject;
  logic [15:0] inj_data;

  cmd_t        q0[$];
  cmd_t        q1[$];
  logic [63:0] exp_acc[$];
  logic [17:0] exp_rd[$];
  ret_t        ret_q[$];
  int          acc_log[$];

  sdram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sdram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PEND_DEPTH(4)) dut (
    .clk_clk    (clk),
    .reset_reset(rst),
    .bus        (bus),
    .arb_err    (arb_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [15:0] rdata_of(input logic [23:0] a);
    return {a[7:0], a[7:0] ^ 8'h5A};
  endfunction

  function automatic logic [63:0] desc(input int p, input logic rd, input logic wr,
                                       input logic [23:0] a, input logic [15:0] d);
    logic [1:0] be;
    be = (p == 0) ? 2'b11 : 2'b01;
    return {20'd0, wr & ~rd, rd, be, a, d};
  endfunction

  task automatic issue(input int p, input logic rd, input logic wr,
                       input logic [23:0] a, input logic [15:0] d, input bit want);
    cmd_t c;
    c = '{rd: rd, wr: wr, addr: a, data: d};
    if (p == 0) q0.push_back(c);
    else        q1.push_back(c);
    if (want) exp_acc.push_back(desc(p, rd, wr, a, d));
    if (rd)   exp_rd.push_back({(p == 0) ? 2'b01 : 2'b10, rdata_of(a)});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_quiet(input int budget);
    int n;
    n = 0;
    while ((q0.size() + q1.size() + exp_acc.size()) != 0 || (bus.r_read | bus.r_write) != 2'b00) begin
      if (n == budget) begin
        check("quiet_timeout", q0.size() + q1.size() + exp_acc.size() + int'(|(bus.r_read | bus.r_write)), 0);
        return;
      end
      @(posedge clk);
      n++;
    end
  endtask

  task automatic wait_acc(input int budget);
    int n;
    n = 0;
    while (exp_acc.size() != 0) begin
      if (n == budget) begin
        check("acc_timeout", exp_acc.size(), 0);
        return;
      end
      @(posedge clk);
      n++;
    end
  endtask

  task automatic wait_rd(input int budget);
    int n;
    n = 0;
    while (exp_rd.size() != 0) begin
      if (n == budget) begin
        check("rd_timeout", exp_rd.size(), 0);
        return;
      end
      @(posedge clk);
      n++;
    end
  endtask

  // Upstream masters: hold each command until accepted, then present the next one.
  initial begin : master_drv
    logic [1:0] acc;
    cmd_t       c;
    bit         got;
    forever begin
      @(negedge clk);
      acc = ~bus.r_waitrequest & (bus.r_read | bus.r_write);
      @(posedge clk);
      #1;
      for (int p = 0; p < 2; p++) begin
        if (acc[p]) begin
          bus.r_read[p]  = 1'b0;
          bus.r_write[p] = 1'b0;
        end
        got = 1'b0;
        if (!bus.r_read[p] && !bus.r_write[p]) begin
          if (p == 0 && q0.size() > 0) begin c = q0.pop_front(); got = 1'b1; end
          else if (p == 1 && q1.size() > 0) begin c = q1.pop_front(); got = 1'b1; end
        end
        if (got) begin
          bus.r_read[p]                 = c.rd;
          bus.r_write[p]                = c.wr;
          bus.r_address[p*ADDR_W +: ADDR_W] = c.addr;
          bus.r_writedata[p*DATA_W +: DATA_W] = c.data;
        end
      end
    end
  end

  // SDRAM read-return model: in-order returns, one per cycle, after lat cycles.
  initial begin : return_drv
    ret_t r;
    forever begin
      @(posedge clk);
      #1;
      bus.av_readdatavalid = 1'b0;
      if (inject) begin
        bus.av_readdatavalid = 1'b1;
        bus.av_readdata      = inj_data;
        inject               = 1'b0;
      end else if (!rdv_hold && ret_q.size() > 0 && ret_q[0].due <= cyc) begin
        r = ret_q.pop_front();
        bus.av_readdatavalid = 1'b1;
        bus.av_readdata      = r.data;
      end
    end
  end

  // Monitor: score accepted commands and read-return strobes.
  always @(negedge clk) begin
    ret_t        r;
    logic [63:0] seen;
    if ((bus.av_read || bus.av_write) && !bus.av_waitrequest) begin
      seen = {20'd0, bus.av_write, bus.av_read, bus.av_byteenable, bus.av_address, bus.av_writedata};
      acc_log.push_back(cyc);
      if (bus.av_read) begin
        r.due  = cyc + lat;
        r.data = rdata_of(bus.av_address);
        ret_q.push_back(r);
      end
      if (exp_acc.size() == 0) check("acc_extra", seen, 64'd0);
      else                     check("acc", seen, exp_acc.pop_front());
    end
    if (bus.av_readdatavalid || bus.r_readdatavalid != 2'b00) begin
      if (exp_rd.size() == 0) check("rd_extra", {46'd0, bus.r_readdatavalid, bus.r_readdata}, 64'd0);
      else check("rd", {46'd0, bus.r_readdatavalid, bus.r_readdata}, {46'd0, exp_rd.pop_front()});
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int t0;
    int n;
    rst                  = 1'b1;
    lat                  = 1;
    rdv_hold             = 1'b0;
    inject               = 1'b0;
    inj_data             = '0;
    bus.r_address        = '0;
    bus.r_read           = '0;
    bus.r_write          = '0;
    bus.r_writedata      = '0;
    bus.r_byteenable     = 4'b0111;
    bus.av_waitrequest   = 1'b0;
    bus.av_readdata      = '0;
    bus.av_readdatavalid = 1'b0;

    // Reset and idle outputs
    do_reset();
    @(negedge clk);
    check("rst_waitreq", bus.r_waitrequest, 2'b11);
    check("rst_rdv", bus.r_readdatavalid, 2'b00);
    check("rst_av_read", bus.av_read, 1'b0);
    check("rst_av_write", bus.av_write, 1'b0);
    check("rst_av_addr", bus.av_address, 24'd0);
    check("rst_err", arb_err, 1'b0);

    // Both ports write continuously: 0,1,0,1,... on consecutive cycles
    @(posedge clk);
    #2;
    t0 = cyc;
    acc_log.delete();
    for (int i = 0; i < 4; i++) begin
      issue(0, 1'b0, 1'b1, 24'h100 + 24'(i), 16'hA000 + 16'(i), 1'b1);
      issue(1, 1'b0, 1'b1, 24'h200 + 24'(i), 16'hB000 + 16'(i), 1'b1);
    end
    wait_quiet(100);
    check("rr_count", acc_log.size(), 8);
    if (acc_log.size() == 8) begin
      check("rr_latency", acc_log[0], t0 + 2);
      check("rr_span", acc_log[7] - acc_log[0], 7);
    end

    // Tag FIFO full: 5th port-0 read stalls, a port-1 write still goes through
    rdv_hold = 1'b1;
    for (int i = 0; i < 5; i++) issue(0, 1'b1, 1'b0, 24'h300 + 24'(i), 16'h0000, i < 4);
    wait_acc(100);
    repeat (3) @(negedge clk);
    check("full_stall_wait", bus.r_waitrequest[0], 1'b1);
    check("full_stall_rd", bus.av_read, 1'b0);
    issue(1, 1'b0, 1'b1, 24'h400, 16'h1234, 1'b1);
    wait_acc(100);
    exp_acc.push_back(desc(0, 1'b1, 1'b0, 24'h304, 16'h0000));
    rdv_hold = 1'b0;
    wait_quiet(100);
    wait_rd(100);

    // Interleaved reads 0,1,1,0 with downstream latency 3
    lat = 3;
    issue(0, 1'b1, 1'b0, 24'h600, 16'h0000, 1'b1);
    wait_quiet(50);
    issue(1, 1'b1, 1'b0, 24'h601, 16'h0000, 1'b1);
    issue(1, 1'b1, 1'b0, 24'h602, 16'h0000, 1'b1);
    wait_quiet(50);
    issue(0, 1'b1, 1'b0, 24'h603, 16'h0000, 1'b1);
    wait_quiet(50);
    wait_rd(50);
    lat = 1;

    // Downstream stall held in BUSY1: command stable, no grant switch
    @(posedge clk);
    #1 bus.av_waitrequest = 1'b1;
    issue(1, 1'b0, 1'b1, 24'h700, 16'hC0DE, 1'b1);
    n = 0;
    @(negedge clk);
    while (bus.av_write !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("stall_grant", bus.av_write, 1'b1);
    issue(0, 1'b0, 1'b1, 24'h701, 16'hD00D, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("stall_addr", bus.av_address, 24'h700);
      check("stall_wait", {bus.av_write, bus.r_waitrequest}, 3'b111);
      @(negedge clk);
    end
    @(posedge clk);
    #1 bus.av_waitrequest = 1'b0;
    @(negedge clk);
    check("stall_release", bus.r_waitrequest, 2'b01);
    wait_quiet(50);

    // Read return with empty FIFO: no strobe, sticky error until reset
    check("err_before", arb_err, 1'b0);
    @(negedge clk);
    exp_rd.push_back({2'b00, 16'hBEEF});
    inj_data = 16'hBEEF;
    inject   = 1'b1;
    wait_rd(10);
    @(negedge clk);
    check("err_set", arb_err, 1'b1);
    repeat (5) @(negedge clk);
    check("err_sticky", arb_err, 1'b1);
    do_reset();
    @(negedge clk);
    check("err_cleared", arb_err, 1'b0);

    // Read and write together on one port: read performed, error flagged
    issue(0, 1'b1, 1'b1, 24'h800, 16'h5555, 1'b1);
    wait_quiet(50);
    wait_rd(50);
    @(negedge clk);
    check("rw_collision_err", arb_err, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Two-port Avalon-MM arbiter that shares the single SDRAM controller slave between two masters: the median-filter pixel reader/writer (port 0) and the Nios II data bridge (port 1). Single-word transfers only, no bursts. A pending-read tag FIFO routes `readdatavalid` back to the issuing port, so pipelined reads from either master return in order to the correct requester. The block sits between the masters and the SDRAM controller inside the `nios2hps` system clock domain.

## Interface
Parameters:
- `ADDR_W`, 24: word address width, 16M x 16-bit SDRAM.
- `DATA_W`, 16: data width; byteenable width is `DATA_W/8`.
- `PEND_DEPTH`, 4: pending-read tag FIFO depth; must be a power of 2 and at least 2.

Ports:
- `clk_clk`  in  1  system clock; all logic rises on this edge.
- `reset_reset`  in  1  synchronous, active-high reset.
- `r_address`  in  2*ADDR_W  port p occupies bits `[p*ADDR_W +: ADDR_W]`.
- `r_read`, `r_write`  in  2  per-port read/write command.
- `r_writedata`  in  2*DATA_W  per-port write data.
- `r_byteenable`  in  2*DATA_W/8  per-port byte enables.
- `r_waitrequest`  out  2  per-port Avalon waitrequest.
- `r_readdata`  out  DATA_W  broadcast of `av_readdata`.
- `r_readdatavalid`  out  2  one-hot read-return strobe.
- `av_address`  out  ADDR_W  command to the SDRAM controller; `av_writedata`, `av_byteenable` are driven alongside it.
- `av_read`, `av_write`  out  1  downstream command strobes.
- `av_waitrequest`  in  1  downstream stall.
- `av_readdata`  in  DATA_W  downstream read data.
- `av_readdatavalid`  in  1  downstream read-return strobe.
- `arb_err`  out  1  sticky protocol-error flag.

## Operation
- States:
  - IDLE: no grant.
  - BUSY0 / BUSY1: grant held by port 0 / port 1.
- Request from port p = `r_read[p] | r_write[p]`. It is eligible unless it is a read while the tag FIFO is full. Writes are never blocked by FIFO state.
- Arbitration runs in IDLE and in every accept cycle. Accept cycle = BUSYg and `av_waitrequest`=0.
  - Round-robin pointer `last`: on a tie, the port other than `last` wins.
  - `last` updates to g on each accept.
- Transitions:
  - IDLE → BUSYp when an eligible request exists.
  - BUSYg: stay while `av_waitrequest`=1.
  - On accept: go to BUSYq if an eligible request exists. Port g's current command is excluded from that same-cycle re-arbitration. Otherwise go to IDLE.
- In BUSYg:
  - `av_*` command outputs mux port g's inputs combinationally.
  - `av_read`/`av_write` follow port g's strobes.
  - `r_waitrequest[g] = av_waitrequest`; the other port sees 1.
- In IDLE: `r_waitrequest` = 2'b11; `av_read` = `av_write` = 0.
- Read accept pushes tag g into the FIFO.
- On `av_readdatavalid`:
  - pop the head tag and pulse `r_readdatavalid[tag]` in the same cycle, combinationally.
  - If the FIFO is empty, assert no port strobe and set `arb_err`.
- Simultaneous push and pop is allowed. Full-eligibility uses the registered count, so a pop does not unblock a read in the same cycle.
- `r_read` and `r_write` both high on the granted port: perform the read, ignore the write, set `arb_err`.
- Reset, including mid-transfer:
  - state → IDLE, `last` → 1 (port 0 wins first tie), FIFO emptied, `arb_err` → 0.
  - Read data returning after reset finds the FIFO empty and sets `arb_err`.

## Timing
- Reset values: `r_waitrequest`=2'b11, `r_readdatavalid`=0, `av_read`=0, `av_write`=0, `arb_err`=0. `av_address`, `av_writedata` and `av_byteenable` are 0 because no port is granted.
- Grant latency: a request first seen at cycle N is driven downstream in cycle N+1. Accept is no earlier than cycle N+1.
- Back-to-back: after an accept at cycle M, the next grant drives its command at M+1, with no idle bubble. Sustained throughput is 1 transfer per cycle when `av_waitrequest`=0.
- Read return: zero added latency; `r_readdatavalid` is concurrent with `av_readdatavalid`.
- Requesters must hold their command stable while their `r_waitrequest` is 1, per the Avalon rule.

## Configuration
- `SDRAM_ARB_FIXED_PRIO_EN`:
  - Defined: port 0 always wins contention, the `last` pointer is removed, and port 1 can starve.
  - Undefined (default): round-robin as described above.

## Test plan
- Reset, then idle: `r_waitrequest`=2'b11, `av_read`=`av_write`=0, `arb_err`=0.
- Both ports write continuously with `av_waitrequest`=0: grants alternate 0,1,0,1 on consecutive cycles, starting with port 0. With `SDRAM_ARB_FIXED_PRIO_EN`, all grants go to port 0.
- Port 0 issues 4 reads with `av_readdatavalid` held off: a 5th port-0 read stalls; a port-1 write is still accepted. Returning data 0x1111..0x4444 pulses `r_readdatavalid`=2'b01 four times, in order.
- Interleaved reads 0,1,1,0 with downstream latency 3: the return strobes are 01,10,10,01 with matching `r_readdata`.
- `av_waitrequest` held high for 5 cycles in BUSY1: the command stays stable, `r_waitrequest[1]` stays 1 until release, and no grant switches.
- Assert `av_readdatavalid` with the FIFO empty: `arb_err`=1, `r_readdatavalid`=0. The flag clears only on `reset_reset`.
